// File: rtl/maze_view_if.sv
// Bus between the maze camera controller and its surroundings: frame/zoom/character inputs
// in, committed zoom and viewport origin out.
interface maze_view_if;
    logic       enable;
    logic       vsync;
    logic       zoom_in;
    logic       zoom_out;
    logic [6:0] char_x;
    logic [6:0] char_y;
    logic [6:0] maze_width;
    logic [6:0] maze_height;
    logic [6:0] tile_width;
    logic [6:0] tile_height;
    logic [6:0] x_coord;
    logic [6:0] y_coord;
    logic       fits;
    logic       frame_done;

    modport master (
        output enable, vsync, zoom_in, zoom_out, char_x, char_y, maze_width, maze_height,
        input  tile_width, tile_height, x_coord, y_coord, fits, frame_done
    );

    modport slave (
        input  enable, vsync, zoom_in, zoom_out, char_x, char_y, maze_width, maze_height,
        output tile_width, tile_height, x_coord, y_coord, fits, frame_done
    );
endinterface

// File: rtl/maze_view_controller.sv
// Frame-synchronous zoom/viewport sequencer: one ZOOM-CALC-CLAMP-COMMIT pass per vsync edge.
// Optional MAZE_SMOOTH_SCROLL_EN limits viewport motion to SCROLL_STEP tiles per frame.
module maze_view_controller #(
    parameter int ZMIN        = 3,
    parameter int ZMAX        = 6,
    parameter int ZINIT       = 4,
    parameter int VS_POL      = 1,
    parameter int SCROLL_STEP = 1
) (
    input logic        clk,
    input logic        reset,
    maze_view_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ZOOM, CALC, CLAMP, COMMIT} state_t;

    state_t             state, state_next;
    logic               vs_q;
    logic               vs_level, vs_edge;
    logic signed [1:0]  pend;
    logic [3:0]         z_cur, z_work, z_sat;
    logic signed [5:0]  z_sum;
    logic               zchg;
    logic [9:0]         cols, rows, cols_c, rows_c;
    logic [13:0]        w_scaled, h_scaled;
    logic               fits_work, fits_out, frame_done;
    logic signed [10:0] tx, ty, tx_c, ty_c, lim_x, lim_y;
    logic [6:0]         nx, ny, nx_c, ny_c, x_coord, y_coord;

    assign vs_level = (bus.vsync == 1'(VS_POL));
    assign vs_edge  = vs_level && !vs_q;

    // vsync level is tracked even through reset so a held pulse cannot look like a fresh edge
    always_ff @(posedge clk) begin
        vs_q <= vs_level;
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.enable) state <= IDLE;
        else                      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (vs_edge) state_next = ZOOM;
            ZOOM:    state_next = CALC;
            CALC:    state_next = CLAMP;
            CLAMP:   state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        z_sum = $signed({2'b00, z_cur}) + $signed({{4{pend[1]}}, pend});
        if (z_sum < $signed(6'(ZMIN)))      z_sat = 4'(ZMIN);
        else if (z_sum > $signed(6'(ZMAX))) z_sat = 4'(ZMAX);
        else                                z_sat = z_sum[3:0];
    end

    // Everything is widened well past 7 bits so a 64-tile maze at 64 px cannot wrap
    always_comb begin
        cols_c   = 10'd640 >> z_work;
        rows_c   = 10'd480 >> z_work;
        w_scaled = {7'b0, bus.maze_width} << z_work;
        h_scaled = {7'b0, bus.maze_height} << z_work;
        tx_c     = $signed({4'b0000, bus.char_x}) - $signed({2'b00, cols_c[9:1]});
        ty_c     = $signed({4'b0000, bus.char_y}) - $signed({2'b00, rows_c[9:1]});
        lim_x    = $signed({4'b0000, bus.maze_width}) - $signed({1'b0, cols});
        lim_y    = $signed({4'b0000, bus.maze_height}) - $signed({1'b0, rows});
    end

    always_comb begin
        nx_c = 7'd0;
        ny_c = 7'd0;
        if (!fits_work && ({3'b000, bus.maze_width} > cols) && (tx >= 0))
            nx_c = (tx > lim_x) ? lim_x[6:0] : tx[6:0];
        if (!fits_work && ({3'b000, bus.maze_height} > rows) && (ty >= 0))
            ny_c = (ty > lim_y) ? lim_y[6:0] : ty[6:0];
    end

`ifdef MAZE_SMOOTH_SCROLL_EN
    function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
        logic [7:0] up, tgt_up;
        up     = {1'b0, cur} + 8'(SCROLL_STEP);
        tgt_up = {1'b0, tgt} + 8'(SCROLL_STEP);
        if ({1'b0, tgt} > up)          return up[6:0];
        else if (tgt_up < {1'b0, cur}) return cur - 7'(SCROLL_STEP);
        else                           return tgt;
    endfunction
`else
    // Direct commit ignores the step size and the zoom-change flag
    logic unused_direct_commit;
    assign unused_direct_commit = (|SCROLL_STEP) ^ zchg;
`endif

    // Pending zoom: newest request wins, a same-cycle in+out cancels, ZOOM consumes it
    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= 2'sd0;
            z_cur      <= 4'(ZINIT);
            z_work     <= 4'(ZINIT);
            zchg       <= 1'b0;
            cols       <= 10'd0;
            rows       <= 10'd0;
            fits_work  <= 1'b0;
            tx         <= 11'sd0;
            ty         <= 11'sd0;
            nx         <= 7'd0;
            ny         <= 7'd0;
            x_coord    <= 7'd0;
            y_coord    <= 7'd0;
            fits_out   <= 1'b0;
            frame_done <= 1'b0;
        end else if (!bus.enable) begin
            pend       <= 2'sd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bus.zoom_in && bus.zoom_out) pend <= 2'sd0;
            else if (bus.zoom_in)            pend <= -2'sd1;
            else if (bus.zoom_out)           pend <= 2'sd1;
            else if (state == ZOOM)          pend <= 2'sd0;

            unique case (state)
                ZOOM: begin
                    z_work <= z_sat;
                    zchg   <= (z_sat != z_cur);
                end
                CALC: begin
                    cols      <= cols_c;
                    rows      <= rows_c;
                    fits_work <= (w_scaled <= 14'd640) && (h_scaled <= 14'd480);
                    tx        <= tx_c;
                    ty        <= ty_c;
                end
                CLAMP: begin
                    nx <= nx_c;
                    ny <= ny_c;
                end
                COMMIT: begin
                    z_cur      <= z_work;
                    fits_out   <= fits_work;
                    frame_done <= 1'b1;
`ifdef MAZE_SMOOTH_SCROLL_EN
                    if (zchg || fits_work) begin
                        x_coord <= nx;
                        y_coord <= ny;
                    end else begin
                        x_coord <= step_toward(x_coord, nx);
                        y_coord <= step_toward(y_coord, ny);
                    end
`else
                    x_coord <= nx;
                    y_coord <= ny;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.tile_width  = {3'b000, z_cur};
    assign bus.tile_height = {3'b000, z_cur};
    assign bus.x_coord     = x_coord;
    assign bus.y_coord     = y_coord;
    assign bus.fits        = fits_out;
    assign bus.frame_done  = frame_done;

endmodule
